// File: rtl/timer_compare_capture.sv
// Compare/capture unit fed by a free-running up counter: compare match, wrap pulse, PWM level,
// and an armed capture FSM with valid/ack handshake. Optional glitch filter: CAP_FILTER_EN.
module timer_compare_capture #(
  parameter int Bits        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [Bits-1:0] count_in,
  input  logic            cmp_wr,
  input  logic [Bits-1:0] cmp_data,
  input  logic            cap_in,
  input  logic            cap_arm,
  input  logic            cap_ack,
  output logic            match_pulse,
  output logic            ovf_pulse,
  output logic            pwm_out,
  output logic [Bits-1:0] cap_value,
  output logic            cap_valid,
  output logic            cap_overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } cap_state_t;

  logic [Bits-1:0]        cmp_shadow;
  logic [Bits-1:0]        cmp_active;
  logic [Bits-1:0]        count_prev;
  logic                   wrap;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_now;
  logic                   level_now;
  logic                   level_last;
  logic                   cap_edge;

  cap_state_t             state;
  cap_state_t             state_next;
  logic [Bits-1:0]        cap_value_next;
  logic                   cap_valid_next;
  logic                   cap_overrun_next;

  assign wrap     = (count_prev == {Bits{1'b1}}) && (count_in == {Bits{1'b0}});
  assign sync_now = sync_q[SYNC_STAGES-1];

  // Compare registers and the registered match / wrap / PWM outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_shadow  <= {Bits{1'b0}};
      cmp_active  <= {Bits{1'b0}};
      count_prev  <= {Bits{1'b0}};
      match_pulse <= 1'b0;
      ovf_pulse   <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      if (cmp_wr) begin
        cmp_shadow <= cmp_data;
      end
      // A write landing on the wrap cycle is still in flight; the old shadow is taken
      if (wrap) begin
        cmp_active <= cmp_shadow;
      end
      count_prev  <= count_in;
      ovf_pulse   <= wrap;
      match_pulse <= (count_in == cmp_active) && (count_in != count_prev);
      pwm_out     <= (count_in < cmp_active);
    end
  end

  // Metastability synchronizer for the asynchronous capture input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
    end
  end

`ifdef CAP_FILTER_EN
  logic [1:0] hist;

  // The filtered level follows the input only once three successive samples agree
  assign level_now = ((sync_now == hist[0]) && (sync_now == hist[1])) ? sync_now : level_last;

  // Sample history for the glitch filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], sync_now};
    end
  end
`else
  assign level_now = sync_now;
`endif

  // Registered rising-edge detector on the (optionally filtered) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_last <= 1'b0;
      cap_edge   <= 1'b0;
    end else begin
      level_last <= level_now;
      cap_edge   <= level_now & ~level_last;
    end
  end

  // Capture FSM state and registered capture outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cap_value   <= {Bits{1'b0}};
      cap_valid   <= 1'b0;
      cap_overrun <= 1'b0;
    end else begin
      state       <= state_next;
      cap_value   <= cap_value_next;
      cap_valid   <= cap_valid_next;
      cap_overrun <= cap_overrun_next;
    end
  end

  // Capture FSM next-state and next-output logic
  always_comb begin
    state_next       = state;
    cap_value_next   = cap_value;
    cap_valid_next   = cap_valid;
    cap_overrun_next = cap_overrun;
    case (state)
      IDLE: begin
        if (cap_arm) begin
          state_next = ARMED;
        end else begin
          state_next = IDLE;
        end
      end
      ARMED: begin
        if (cap_edge) begin
          cap_value_next = count_in;
          cap_valid_next = 1'b1;
          state_next     = CAPTURED;
        end else begin
          state_next = ARMED;
        end
      end
      CAPTURED: begin
        // Acknowledge wins over a coincident edge, which is dropped
        if (cap_ack) begin
          cap_valid_next   = 1'b0;
          cap_overrun_next = 1'b0;
          state_next       = cap_arm ? ARMED : IDLE;
        end else if (cap_edge) begin
          cap_overrun_next = 1'b1;
        end else begin
          state_next = CAPTURED;
        end
      end
      default: begin
        state_next       = IDLE;
        cap_valid_next   = 1'b0;
        cap_overrun_next = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/timer_compare_capture.md
Name: timer_compare_capture

Overview:
- Compare/capture unit that sits directly downstream of the free-running up counter and consumes its count output.
- Produces a compare-match pulse, a wrap (overflow) pulse and a PWM level.
- Timestamps rising edges of an asynchronous external input through an armed capture state machine with a valid/ack handshake.

Parameters:
Bits, 4, width of count_in, compare and capture registers
SYNC_STAGES, 2, synchronizer flops on cap_in (legal range 2..3)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
count_in  input  Bits  free-running count; increments by 1 per clk and wraps
cmp_wr  input  1  write strobe for compare value
cmp_data  input  Bits  compare value to load
cap_in  input  1  asynchronous external event input
cap_arm  input  1  arm the capture FSM
cap_ack  input  1  consumer acknowledge of a captured value
match_pulse  output  1  one-cycle pulse on compare match
ovf_pulse  output  1  one-cycle pulse on count wrap
pwm_out  output  1  high while count_in < active compare value
cap_value  output  Bits  captured count
cap_valid  output  1  cap_value holds an unacknowledged capture
cap_overrun  output  1  sticky flag: an edge arrived while a capture was pending

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0, cmp_shadow=0, cmp_active=0, count_prev=0, synchronizer flops 0, FSM=IDLE.
- Compare register:
  - cmp_wr loads cmp_data into cmp_shadow on the next edge.
  - cmp_shadow copies into cmp_active only on the wrap cycle (count_prev=all-ones and count_in=0).
  - If cmp_wr and wrap occur in the same cycle, cmp_active takes the old shadow value; the new value applies at the next wrap.
- count_prev registers count_in every cycle.
- ovf_pulse: registered. High for exactly one cycle, in the cycle after count_prev=all-ones and count_in=0 is seen.
- match_pulse: registered, 1-cycle latency. High one cycle after count_in==cmp_active and count_in!=count_prev. A stalled count therefore produces a single pulse.
- pwm_out: registered, pwm_out <= (count_in < cmp_active), unsigned compare.
  - cmp_active=0 gives a constant 0.
  - cmp_active=all-ones gives 0 only for the one count at all-ones.
- Capture path:
  - cap_in passes through SYNC_STAGES flops, then a rising-edge detector (sync_last==0, sync_now==1).
  - Latency from a cap_in rise to edge detect is SYNC_STAGES+1 clocks.
- Capture FSM:
  - IDLE: cap_arm -> ARMED. Edges are ignored.
  - ARMED: on an edge, cap_value <= count_in of that cycle, cap_valid <= 1, go to CAPTURED. cap_arm is ignored.
  - CAPTURED: cap_valid=1 and cap_value is held.
    - An edge sets cap_overrun=1; cap_value is not overwritten.
    - cap_ack -> cap_valid <= 0, cap_overrun <= 0, next state IDLE; next state is ARMED if cap_arm is also high that cycle.
    - An edge in the same cycle as cap_ack is dropped and does not set overrun.
  - cap_ack in IDLE or ARMED has no effect.
- Reset asserted mid-operation forces every register to its reset value at once. A pending capture is lost.

Optional Feature:
CAP_FILTER_EN
- Defined: a glitch filter sits after the synchronizer. The filtered level changes only after 3 consecutive identical synchronized samples, so a pulse shorter than 3 clocks is rejected. Edge-detect latency becomes SYNC_STAGES+3 clocks.
- Undefined: no filter; edge detect works directly on the synchronizer output.

Test Plan:
- Reset: hold reset_n=0 with count_in running and cap_in toggling -> all outputs 0, FSM IDLE. Release -> no pulses until the conditions are met.
- Compare/PWM (Bits=4): cmp_wr with cmp_data=5, count 0..15 twice -> cmp_active changes only at the first wrap. Then match_pulse on the cycle after count_in=5; pwm_out high for counts 0..4 (seen 1 cycle late); ovf_pulse once per wrap.
- Write at wrap: cmp_wr(9) in the same cycle as the 15->0 wrap -> the old value is used for that period, 9 from the next wrap.
- Capture handshake: cap_arm; raise cap_in when count_in=3 -> cap_valid with cap_value=(3+SYNC_STAGES+1) mod 16. cap_ack -> cap_valid=0, state IDLE.
- Overrun: with a capture pending, a second cap_in edge -> cap_overrun=1 and cap_value unchanged. cap_ack together with cap_arm -> both flags clear, FSM ARMED, next edge captured.
- Filter (CAP_FILTER_EN): a 2-clock cap_in pulse -> no capture. A 4-clock pulse -> capture, SYNC_STAGES+3 clocks after the rise.
